generador_senales_rtc: RTL and testbench
========================================

Name: generador_senales_rtc

Overview:
- Timing sequencer for the multiplexed address/data RTC bus; it sits directly upstream of the RTC protocol stage.
- On each start request it runs one fixed 70-tick transaction frame.
- It produces the frame counter contador_todo and the active-low bus strobes (ChipSelect, Read, Write, AoD) that the protocol stage uses.
  - The protocol stage uses them to steer the tri-state bus and to capture read data.
- It also latches the transaction direction as IndicadorMaquina (0 = write, 1 = read).

Parameters:
- TICK_DIV, 10, clk cycles per frame tick (10 = 100 ns/tick at 100 MHz); legal range 1..255.
- FRAME_LAST, 69, last tick index of a frame (frame = ticks 0..69).

Ports:
- clk  input  1  100 MHz system clock; every register is clocked on its rising edge.
- reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
- start  input  1  request a transaction; sampled only in IDLE.
- rw  input  1  direction, sampled together with start: 0 = write, 1 = read.
- contador_todo  output  7  current frame tick.
- ChipSelect  output  1  RTC chip select, active low.
- Read  output  1  RTC read strobe, active low.
- Write  output  1  RTC write strobe, active low.
- AoD  output  1  bus phase: 0 = address/command, 1 = data.
- IndicadorMaquina  output  1  latched rw of the current transaction.
- busy  output  1  high while a frame runs.
- done  output  1  one-clk pulse at frame end.

Behaviour:
- Reset values, and values in IDLE:
  - contador_todo = 0, ChipSelect = 1, Read = 1, Write = 1, AoD = 1.
  - IndicadorMaquina = 0, busy = 0, done = 0.
  - All outputs are registered.
- State machine:
  - IDLE: when start = 1, go to RUN on the next edge, and in that edge:
    - IndicadorMaquina <= rw, contador_todo <= 0, prescaler <= 0, busy <= 1.
  - RUN: the prescaler counts 0..TICK_DIV-1.
    - When it wraps, contador_todo increments.
    - At the wrap with contador_todo = FRAME_LAST, go to DONE instead of incrementing.
  - DONE: lasts exactly one clk.
    - done = 1 and busy = 0; contador_todo returns to 0 and strobes return to idle values.
    - Next state is IDLE. start in DONE is ignored and a new frame needs start in IDLE, so back-to-back frames are separated by at least 2 clks.
- start while busy: ignored and not queued. rw changes during RUN: ignored.
- Strobe decode:
  - Strobes are registered and computed from the next value of contador_todo, so they change on the same edge as the counter.
  - Ranges below are inclusive tick indices, valid only in RUN. Every tick outside the listed ranges has the idle value.
  - ChipSelect = 0 for ticks 1..35 and 39..68.
  - Sub-cycle 1, both directions: AoD = 0 for ticks 1..11; Write = 0 for ticks 2..9.
  - Write mode (IndicadorMaquina = 0):
    - Ticks 12..35: AoD = 1, with Write = 0 for ticks 20..30.
    - Ticks 39..48: AoD = 0, with Write = 0 for ticks 40..47.
    - Ticks 49..69: AoD = 1; Read stays 1.
  - Read mode (IndicadorMaquina = 1):
    - Ticks 12..35: AoD = 1, with Write = 1.
    - Ticks 39..48: AoD = 0, with Write = 0 for ticks 40..47.
    - Ticks 49..69: AoD = 1, with Read = 0 for ticks 57..67 (0x39..0x43, the downstream capture window).
  - Ticks 36..38 form a separation gap: ChipSelect = 1 on ticks 36..38 and AoD = 1 on ticks 36..38. Tick 37 itself never asserts any strobe.
- Invariants, checked in every clk:
  - Read and Write are never both 0.
  - Read = 0 only while AoD = 1 and ChipSelect = 0.
  - Write = 0 only while ChipSelect = 0.
  - AoD changes only while Read = 1 and Write = 1.
- Reset asserted mid-frame: on the next edge all outputs take their reset values and the state is IDLE; no done pulse is produced.
- reset and start both asserted: reset wins.
- Width: contador_todo never exceeds FRAME_LAST and never wraps through 127. The prescaler width is 8 bits.

Test Plan:
- Reset, then idle: hold reset 3 clks, then release with start = 0 for 20 clks -> contador_todo = 0, ChipSelect = Read = Write = AoD = 1, busy = 0, done = 0 throughout.
- Write frame, TICK_DIV = 1: start = 1, rw = 0 for one clk.
  - Write = 0 exactly at ticks 2..9, 20..30 and 40..47; AoD = 1 during 20..30; Read always 1.
  - done pulses once, 71 clks after start is sampled; busy = 1 for 70 clks.
- Read frame, TICK_DIV = 1: start = 1, rw = 1.
  - IndicadorMaquina = 1; Read = 0 exactly at ticks 0x39..0x43 with AoD = 1 and ChipSelect = 0.
  - Write = 0 only at ticks 2..9 and 40..47; ticks 36..38 have ChipSelect = 1.
- Prescaler, TICK_DIV = 10: read frame -> each contador_todo value is held 10 clks; the Read low pulse is 110 clks; done arrives 701 clks after start.
- Ignored requests: during a read frame at tick 20, pulse start with rw = 0 -> IndicadorMaquina stays 1, no second frame, and exactly one done pulse.
- Reset mid-frame: assert reset at tick 58 while Read = 0 -> next edge gives Read = 1, contador_todo = 0, busy = 0; no done pulse; a later start runs a full frame normally.
- All runs: the bench checks the strobe invariants every clk.

Source files
------------

// File: rtl/generador_senales_rtc.sv
// Frame sequencer for the multiplexed RTC bus: one 70-tick frame of active-low strobes per start.
// Latency: outputs registered; frame spans 70*TICK_DIV clks after start is sampled, then one done clk.
// Backpressure: none; start is accepted only in IDLE, and requests while busy are dropped.
module generador_senales_rtc #(
    parameter int TICK_DIV   = 10,
    parameter int FRAME_LAST = 69
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       rw,
    output logic [6:0] contador_todo,
    output logic       ChipSelect,
    output logic       Read,
    output logic       Write,
    output logic       AoD,
    output logic       IndicadorMaquina,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_FIN
    } state_t;

    localparam logic [7:0] PRESC_LAST = 8'(TICK_DIV - 1);
    localparam logic [6:0] TICK_LAST  = 7'(FRAME_LAST);

    state_t     state;
    logic [7:0] prescaler;

    function automatic logic in_range(input logic [6:0] t, input logic [6:0] lo, input logic [6:0] hi);
        return (t >= lo) && (t <= hi);
    endfunction

    // Strobe pattern for tick t in RUN, packed as {ChipSelect, Read, Write, AoD}.
    function automatic logic [3:0] decode(input logic [6:0] t, input logic im);
        logic cs_n;
        logic rd_n;
        logic wr_n;
        logic aod;
        cs_n = !(in_range(t, 7'd1, 7'd35) || in_range(t, 7'd39, 7'd68));
        aod  = !(in_range(t, 7'd1, 7'd11) || in_range(t, 7'd39, 7'd48));
        wr_n = !(in_range(t, 7'd2, 7'd9) || in_range(t, 7'd40, 7'd47) ||
                 (!im && in_range(t, 7'd20, 7'd30)));
        rd_n = !(im && in_range(t, 7'd57, 7'd67));
        return {cs_n, rd_n, wr_n, aod};
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= ST_IDLE;
            prescaler        <= 8'd0;
            contador_todo    <= 7'd0;
            ChipSelect       <= 1'b1;
            Read             <= 1'b1;
            Write            <= 1'b1;
            AoD              <= 1'b1;
            IndicadorMaquina <= 1'b0;
            busy             <= 1'b0;
            done             <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state            <= ST_RUN;
                        IndicadorMaquina <= rw;
                        contador_todo    <= 7'd0;
                        prescaler        <= 8'd0;
                        busy             <= 1'b1;
                        {ChipSelect, Read, Write, AoD} <= decode(7'd0, rw);
                    end
                end
                ST_RUN: begin
                    if (prescaler == PRESC_LAST) begin
                        prescaler <= 8'd0;
                        if (contador_todo == TICK_LAST) begin
                            state         <= ST_FIN;
                            contador_todo <= 7'd0;
                            busy          <= 1'b0;
                            done          <= 1'b1;
                            {ChipSelect, Read, Write, AoD} <= 4'b1111;
                        end else begin
                            // Strobes follow the incremented tick so both change on the same edge.
                            contador_todo <= contador_todo + 7'd1;
                            {ChipSelect, Read, Write, AoD} <= decode(contador_todo + 7'd1, IndicadorMaquina);
                        end
                    end else begin
                        prescaler <= prescaler + 8'd1;
                    end
                end
                ST_FIN: begin
                    state            <= ST_IDLE;
                    done             <= 1'b0;
                    IndicadorMaquina <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_generador_senales_rtc.sv
// Bench for generador_senales_rtc: two instances (TICK_DIV 1 and 10) share stimulus and are
// compared every clk against an elapsed-clock frame model, plus literal frame measurements.
module tb_generador_senales_rtc;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       start;
    logic       rw;
    logic [6:0] cnt  [2];
    logic       cs   [2];
    logic       rd   [2];
    logic       wr   [2];
    logic       aod  [2];
    logic       im   [2];
    logic       busy [2];
    logic       done [2];

    generador_senales_rtc #(.TICK_DIV(1), .FRAME_LAST(69)) dut1 (
        .clk(clk), .reset(reset), .start(start), .rw(rw),
        .contador_todo(cnt[0]), .ChipSelect(cs[0]), .Read(rd[0]), .Write(wr[0]),
        .AoD(aod[0]), .IndicadorMaquina(im[0]), .busy(busy[0]), .done(done[0])
    );

    generador_senales_rtc #(.TICK_DIV(10), .FRAME_LAST(69)) dut10 (
        .clk(clk), .reset(reset), .start(start), .rw(rw),
        .contador_todo(cnt[1]), .ChipSelect(cs[1]), .Read(rd[1]), .Write(wr[1]),
        .AoD(aod[1]), .IndicadorMaquina(im[1]), .busy(busy[1]), .done(done[1])
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int div_of(input int i);
        return (i == 0) ? 1 : 10;
    endfunction

    function automatic logic in_rng(input int t, input int lo, input int hi);
        return (t >= lo) && (t <= hi);
    endfunction

    // Per-tick strobe tables built from the bus timing windows.
    logic t_cs [70];
    logic t_aod [70];
    logic t_wr_w [70];
    logic t_wr_r [70];
    logic t_rd_r [70];

    initial begin
        for (int t = 0; t < 70; t++) begin
            t_cs[t]   = !(in_rng(t, 1, 35) || in_rng(t, 39, 68));
            t_aod[t]  = !(in_rng(t, 1, 11) || in_rng(t, 39, 48));
            t_wr_r[t] = !(in_rng(t, 2, 9) || in_rng(t, 40, 47));
            t_wr_w[t] = t_wr_r[t] && !in_rng(t, 20, 30);
            t_rd_r[t] = !in_rng(t, 57, 67);
        end
    end

    // Model: clocks elapsed since the accepting edge; tick = elapsed / TICK_DIV.
    int   m_st [2];
    int   m_k  [2];
    logic m_im [2];
    int   cyc = 0;
    logic rst_q = 1'b1;

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_q <= reset;
        for (int i = 0; i < 2; i++) begin
            if (reset) begin
                m_st[i] <= 0;
                m_k[i]  <= 0;
                m_im[i] <= 1'b0;
            end else begin
                case (m_st[i])
                    0: if (start) begin
                        m_st[i] <= 1;
                        m_k[i]  <= 0;
                        m_im[i] <= rw;
                    end
                    1: if (m_k[i] + 1 == 70 * div_of(i)) m_st[i] <= 2;
                       else m_k[i] <= m_k[i] + 1;
                    default: begin
                        m_st[i] <= 0;
                        m_im[i] <= 1'b0;
                    end
                endcase
            end
        end
    end

    logic chk_on = 1'b0;
    int   clr_gen = 0;
    int   seen_gen = 0;
    int   start_cyc = 0;
    int   busy_n [2];
    int   wr_n [2];
    int   rd_n [2];
    int   done_n [2];
    int   lat [2];
    int   h57 [2];
    logic p_aod [2] = '{1'b1, 1'b1};
    logic p_rd  [2] = '{1'b1, 1'b1};
    logic p_wr  [2] = '{1'b1, 1'b1};

    always @(negedge clk) begin
        if (chk_on) begin
            if (clr_gen != seen_gen) begin
                seen_gen = clr_gen;
                for (int i = 0; i < 2; i++) begin
                    busy_n[i] = 0; wr_n[i] = 0; rd_n[i] = 0;
                    done_n[i] = 0; lat[i] = 0; h57[i] = 0;
                end
            end
            for (int i = 0; i < 2; i++) begin
                int   tick;
                int   e_cnt;
                logic e_cs, e_rd, e_wr, e_aod, e_im, e_busy, e_done;
                e_cnt = 0; e_cs = 1; e_rd = 1; e_wr = 1; e_aod = 1;
                e_im = 0; e_busy = 0; e_done = 0;
                if (m_st[i] == 1) begin
                    tick   = m_k[i] / div_of(i);
                    e_cnt  = tick;
                    e_cs   = t_cs[tick];
                    e_aod  = t_aod[tick];
                    e_wr   = m_im[i] ? t_wr_r[tick] : t_wr_w[tick];
                    e_rd   = m_im[i] ? t_rd_r[tick] : 1'b1;
                    e_im   = m_im[i];
                    e_busy = 1;
                end else if (m_st[i] == 2) begin
                    e_im   = m_im[i];
                    e_done = 1;
                end
                chk($sformatf("contador_todo[%0d]", i), int'(cnt[i]), e_cnt);
                chk($sformatf("ChipSelect[%0d]", i), int'(cs[i]), int'(e_cs));
                chk($sformatf("Read[%0d]", i), int'(rd[i]), int'(e_rd));
                chk($sformatf("Write[%0d]", i), int'(wr[i]), int'(e_wr));
                chk($sformatf("AoD[%0d]", i), int'(aod[i]), int'(e_aod));
                chk($sformatf("IndicadorMaquina[%0d]", i), int'(im[i]), int'(e_im));
                chk($sformatf("busy[%0d]", i), int'(busy[i]), int'(e_busy));
                chk($sformatf("done[%0d]", i), int'(done[i]), int'(e_done));
                // Strobe invariants
                chk($sformatf("inv_rd_wr[%0d]", i), int'(!rd[i] && !wr[i]), 0);
                chk($sformatf("inv_rd_ctx[%0d]", i), int'(!rd[i] && !(aod[i] && !cs[i])), 0);
                chk($sformatf("inv_wr_cs[%0d]", i), int'(!wr[i] && cs[i]), 0);
                if (!rst_q && aod[i] != p_aod[i])
                    chk($sformatf("inv_aod_change[%0d]", i), int'(rd[i] && wr[i] && p_rd[i] && p_wr[i]), 1);
                p_aod[i] = aod[i]; p_rd[i] = rd[i]; p_wr[i] = wr[i];
                if (busy[i]) busy_n[i]++;
                if (!wr[i]) wr_n[i]++;
                if (!rd[i]) rd_n[i]++;
                if (busy[i] && cnt[i] == 7'd57) h57[i]++;
                if (done[i]) begin
                    done_n[i]++;
                    lat[i] = cyc - start_cyc;
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic launch(input logic dir);
        clr_gen++;
        start_cyc = cyc;
        start = 1'b1;
        rw = dir;
        step(1);
        start = 1'b0;
        rw = 1'($urandom_range(0, 1));
    endtask

    task automatic wait_tick(input int t);
        int n;
        n = 0;
        while (cnt[0] != 7'(t) && n < 200) begin
            step(1);
            n++;
        end
        if (n >= 200) chk("wait_tick_timeout", 0, 1);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        rw    = 1'b0;
        step(1);
        chk_on = 1'b1;
        step(3);
        reset = 1'b0;
        step(20);
        chk("idle_cnt", int'(cnt[0]), 0);
        chk("idle_cs", int'(cs[1]), 1);
        chk("idle_busy", int'(busy[0]), 0);

        // Write frame
        launch(1'b0);
        step(720);
        chk("wr_latency_div1", lat[0], 71);
        chk("wr_latency_div10", lat[1], 701);
        chk("wr_done_count_div1", done_n[0], 1);
        chk("wr_busy_clks_div1", busy_n[0], 70);
        chk("wr_busy_clks_div10", busy_n[1], 700);
        chk("wr_write_low_div1", wr_n[0], 27);
        chk("wr_write_low_div10", wr_n[1], 270);
        chk("wr_read_low_div1", rd_n[0], 0);

        // Read frame with a stray write request at tick 20
        launch(1'b1);
        wait_tick(20);
        start = 1'b1;
        rw = 1'b0;
        step(1);
        start = 1'b0;
        chk("rd_im_held_div1", int'(im[0]), 1);
        chk("rd_im_held_div10", int'(im[1]), 1);
        step(720);
        chk("rd_done_count_div1", done_n[0], 1);
        chk("rd_done_count_div10", done_n[1], 1);
        chk("rd_latency_div10", lat[1], 701);
        chk("rd_read_low_div1", rd_n[0], 11);
        chk("rd_read_low_div10", rd_n[1], 110);
        chk("rd_write_low_div1", wr_n[0], 16);
        chk("rd_tick_hold_div10", h57[1], 10);
        chk("rd_tick_hold_div1", h57[0], 1);

        // Reset mid-frame while Read is low
        launch(1'b1);
        wait_tick(58);
        chk("mid_read_low", int'(rd[0]), 0);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        chk("mid_read_idle", int'(rd[0]), 1);
        chk("mid_cnt_zero", int'(cnt[0]), 0);
        chk("mid_busy_div1", int'(busy[0]), 0);
        chk("mid_busy_div10", int'(busy[1]), 0);
        step(5);
        chk("mid_no_done_div1", done_n[0], 0);
        chk("mid_no_done_div10", done_n[1], 0);
        launch(1'b0);
        step(720);
        chk("post_latency_div1", lat[0], 71);
        chk("post_latency_div10", lat[1], 701);
        chk("post_done_div10", done_n[1], 1);

        // Random requests, directions and occasional resets
        for (int n = 0; n < 20000; n++) begin
            start = ($urandom_range(0, 3) == 0);
            rw    = 1'($urandom_range(0, 1));
            reset = ($urandom_range(0, 599) == 0);
            step(1);
        end
        reset = 1'b0;
        start = 1'b0;
        step(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
